// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Moore FSM sequencing fetch/decode/execute/advance for one core.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter logic [3:0] HALT_OP      = 4'hF,
    parameter int         EXEC_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic        ir_write,
    output logic [7:0]  pc_add,
    output logic        decode_valid,
    output logic        exec_en,
    output logic        halted,
    output logic        fault,
    output logic [7:0]  retired,
    output logic [2:0]  state
);

    localparam int                 CNT_W    = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(EXEC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_ADVANCE = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic [7:0]       retired_q, retired_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_taken_q, br_taken_d;
    logic [6:0]       br_tgt_q, br_tgt_d;

    // Only the opcode field and the even part of the target are meaningful here.
    logic unused_inputs;
    assign unused_inputs = ^{instr[11:0], branch_target[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= 8'd0;
            retired_q  <= 8'd0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
            br_taken_q <= 1'b0;
            br_tgt_q   <= 7'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            retired_q  <= retired_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
            br_taken_q <= br_taken_d;
            br_tgt_q   <= br_tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        retired_d  = retired_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        br_taken_d = br_taken_q;
        br_tgt_d   = br_tgt_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (instr[15:12] == HALT_OP) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                    cnt_d   = '0;
                end
            end
            S_EXECUTE: begin
                // Completion outranks a timeout landing in the same cycle.
                if (exec_done) begin
                    br_taken_d = branch_taken;
                    br_tgt_d   = branch_target[7:1];
                    state_d    = S_ADVANCE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ADVANCE: begin
                pc_d      = br_taken_q ? {br_tgt_q, 1'b0} : (pc_q + 8'd2);
                retired_d = (retired_q == 8'hFF) ? retired_q : (retired_q + 8'd1);
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ir_write     = (state_q == S_FETCH);
        decode_valid = (state_q == S_DECODE);
        exec_en      = (state_q == S_EXECUTE);
        halted       = (state_q == S_HALT);
    end

    assign pc_add  = pc_q;
    assign retired = retired_q;
    assign fault   = fault_q;
    assign state   = state_q;

endmodule

`default_nettype wire
